// File: rtl/wave_pkg.sv
// Shared types and default parameter values for the waveform period/extrema monitor.
package wave_pkg;

  localparam int unsigned DEFAULT_MID      = 128;
  localparam int unsigned DEFAULT_HYST     = 8;
  localparam int unsigned DEFAULT_PERIOD_W = 16;

  // StFirst: armed and seen low, waiting for the first rising crossing.
  // StMeasLo: counting, waiting for the signal to drop low again.
  // StMeasHi: counting, waiting for the second rising crossing.
  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFirst,
    StMeasLo,
    StMeasHi,
    StDone
  } state_t;

endpackage

// File: rtl/wave_level_cmp.sv
// Combinational level classifier: flags samples at or beyond the hysteresis thresholds.
module wave_level_cmp
  import wave_pkg::*;
#(
  parameter int unsigned MID  = DEFAULT_MID,
  parameter int unsigned HYST = DEFAULT_HYST
) (
  input  logic [7:0] sample_in,
  output logic       is_low,
  output logic       is_high
);

  // Thresholds fixed at elaboration; MID-HYST and MID+HYST must stay within 0..255.
  localparam logic [7:0] LO_TH = 8'(MID - HYST);
  localparam logic [7:0] HI_TH = 8'(MID + HYST);

  // Samples strictly between the thresholds assert neither flag.
  always_comb begin
    is_low  = (sample_in <= LO_TH);
    is_high = (sample_in >= HI_TH);
  end

endmodule

// File: rtl/wave_monitor.sv
// Measures one period of a sampled waveform (rising crossing to rising crossing) and
// reports the period length in accepted samples plus the max/min seen within it.
module wave_monitor
  import wave_pkg::*;
#(
  parameter int unsigned MID      = DEFAULT_MID,
  parameter int unsigned HYST     = DEFAULT_HYST,
  parameter int unsigned PERIOD_W = DEFAULT_PERIOD_W
) (
  input  logic                clk_50MHz,
  input  logic                reset,
  input  logic [7:0]          sample_in,
  input  logic                sample_valid,
  input  logic                start,
  output logic                busy,
  output logic [PERIOD_W-1:0] period_out,
  output logic [7:0]          max_out,
  output logic [7:0]          min_out,
  output logic                result_valid,
  output logic                timeout
);

  localparam logic [PERIOD_W-1:0] CNT_LIMIT = '1;

  state_t              r_state, w_state_d;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_d;
  logic [7:0]          r_max, w_max_d;
  logic [7:0]          r_min, w_min_d;
  logic [PERIOD_W-1:0] r_period, w_period_d;
  logic [7:0]          r_max_out, w_max_out_d;
  logic [7:0]          r_min_out, w_min_out_d;
  logic                r_result_valid, w_result_valid_d;
  logic                r_timeout, w_timeout_d;

  logic                w_is_low, w_is_high;
  logic [PERIOD_W-1:0] w_cnt_inc;
  logic                w_hit_limit;
  logic [7:0]          w_max_upd, w_min_upd;

  wave_level_cmp #(
    .MID  (MID),
    .HYST (HYST)
  ) u_level_cmp (
    .sample_in (sample_in),
    .is_low    (w_is_low),
    .is_high   (w_is_high)
  );

  // Counter step, timeout detection and running extrema including the current sample.
  always_comb begin
    w_cnt_inc   = r_cnt + PERIOD_W'(1);
    w_hit_limit = (w_cnt_inc == CNT_LIMIT);
    w_max_upd   = (sample_in > r_max) ? sample_in : r_max;
    w_min_upd   = (sample_in < r_min) ? sample_in : r_min;
  end

  // Next-state and datapath decisions; every path holds unless a sample is accepted.
  always_comb begin
    w_state_d        = r_state;
    w_cnt_d          = r_cnt;
    w_max_d          = r_max;
    w_min_d          = r_min;
    w_period_d       = r_period;
    w_max_out_d      = r_max_out;
    w_min_out_d      = r_min_out;
    w_result_valid_d = 1'b0;
    w_timeout_d      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StArm;
          w_cnt_d   = '0;
          w_max_d   = 8'h00;
          w_min_d   = 8'hFF;
        end
      end
      StArm: begin
        if (sample_valid) begin
          if (w_hit_limit) begin
            w_state_d   = StIdle;
            w_timeout_d = 1'b1;
          end else begin
            w_cnt_d = w_cnt_inc;
            if (w_is_low) w_state_d = StFirst;
          end
        end
      end
      StFirst: begin
        // The crossing restarts the count at 1, so it takes priority over the limit.
        if (sample_valid) begin
          if (w_is_high) begin
            w_state_d = StMeasLo;
            w_cnt_d   = PERIOD_W'(1);
            w_max_d   = sample_in;
            w_min_d   = sample_in;
          end else if (w_hit_limit) begin
            w_state_d   = StIdle;
            w_timeout_d = 1'b1;
          end else begin
            w_cnt_d = w_cnt_inc;
          end
        end
      end
      StMeasLo: begin
        if (sample_valid) begin
          if (w_hit_limit) begin
            w_state_d   = StIdle;
            w_timeout_d = 1'b1;
          end else begin
            w_cnt_d = w_cnt_inc;
            w_max_d = w_max_upd;
            w_min_d = w_min_upd;
            if (w_is_low) w_state_d = StMeasHi;
          end
        end
      end
      StMeasHi: begin
        // The second crossing closes the period and is not part of it.
        if (sample_valid) begin
          if (w_is_high) begin
            w_state_d        = StDone;
            w_period_d       = r_cnt;
            w_max_out_d      = r_max;
            w_min_out_d      = r_min;
            w_result_valid_d = 1'b1;
          end else if (w_hit_limit) begin
            w_state_d   = StIdle;
            w_timeout_d = 1'b1;
          end else begin
            w_cnt_d = w_cnt_inc;
            w_max_d = w_max_upd;
            w_min_d = w_min_upd;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset overriding all inputs.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_max          <= 8'h00;
      r_min          <= 8'h00;
      r_period       <= '0;
      r_max_out      <= 8'h00;
      r_min_out      <= 8'h00;
      r_result_valid <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_max          <= w_max_d;
      r_min          <= w_min_d;
      r_period       <= w_period_d;
      r_max_out      <= w_max_out_d;
      r_min_out      <= w_min_out_d;
      r_result_valid <= w_result_valid_d;
      r_timeout      <= w_timeout_d;
    end
  end

  assign busy         = (r_state != StIdle);
  assign period_out   = r_period;
  assign max_out      = r_max_out;
  assign min_out      = r_min_out;
  assign result_valid = r_result_valid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_wave_monitor.sv
// Scoreboard bench for wave_monitor: stimulus pushes expected results, a negedge
// monitor pops and compares on every result_valid pulse.
module tb_wave_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sample_in;
  logic        sample_valid;
  logic        start;
  logic        busy;
  logic [15:0] period_out;
  logic [7:0]  max_out;
  logic [7:0]  min_out;
  logic        result_valid;
  logic        timeout;

  // Second instance with an 8-bit period counter for the timeout case.
  logic [7:0]  s8_sample;
  logic        s8_valid;
  logic        s8_start;
  logic        t8_busy;
  logic [7:0]  t8_period;
  logic [7:0]  t8_max;
  logic [7:0]  t8_min;
  logic        t8_rv;
  logic        t8_timeout;

  always #10 clk = ~clk;

  wave_monitor dut (
    .clk_50MHz    (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .start        (start),
    .busy         (busy),
    .period_out   (period_out),
    .max_out      (max_out),
    .min_out      (min_out),
    .result_valid (result_valid),
    .timeout      (timeout)
  );

  wave_monitor #(
    .PERIOD_W (8)
  ) dut8 (
    .clk_50MHz    (clk),
    .reset        (reset),
    .sample_in    (s8_sample),
    .sample_valid (s8_valid),
    .start        (s8_start),
    .busy         (t8_busy),
    .period_out   (t8_period),
    .max_out      (t8_max),
    .min_out      (t8_min),
    .result_valid (t8_rv),
    .timeout      (t8_timeout)
  );

  typedef struct {
    int period;
    int mx;
    int mn;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_pop;
  int         n_checks  = 0;
  int         n_fail    = 0;
  int         n_results = 0;
  logic [7:0] wave [32];

  function automatic void check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  // Monitor: every result_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      check("main_no_timeout", int'(timeout), 0);
      if (result_valid) begin
        check("result_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e_pop = exp_q.pop_front();
          check("period_out", int'(period_out), e_pop.period);
          check("max_out", int'(max_out), e_pop.mx);
          check("min_out", int'(min_out), e_pop.mn);
        end
        n_results++;
      end
    end
  end

  task automatic step(input logic [7:0] s, input logic v, input logic st, input logic rst);
    @(posedge clk);
    #1;
    sample_in    = s;
    sample_valid = v;
    start        = st;
    reset        = rst;
  endtask

  // Loops the wave table; starts at the first table wrap after 32 cycles, fires a second
  // (ignored) start 40 cycles later, optionally resets reset_at cycles after start.
  task automatic drive_wave(input string tag, input bit half, input int reset_at,
                            output int lat);
    int   idx;
    int   base;
    int   start_c;
    bit   ph;
    bit   got;
    logic v;
    logic st;
    logic rst;
    idx     = 0;
    base    = n_results;
    start_c = -1;
    ph      = 1'b0;
    got     = 1'b0;
    lat     = -1;
    for (int c = 0; c < 600; c++) begin
      v  = half ? ph : 1'b1;
      ph = ~ph;
      st = 1'b0;
      if (start_c < 0 && c >= 32 && idx == 0) begin
        st      = 1'b1;
        start_c = c;
        if (reset_at < 0) exp_q.push_back('{32, 255, 0});
      end else if (start_c >= 0 && c == start_c + 40) begin
        st = 1'b1;
      end
      rst = (reset_at >= 0 && start_c >= 0 && c == start_c + reset_at);
      step(wave[idx], v, st, rst);
      if (v) idx = (idx + 1) % 32;
      if (rst) break;
      if (start_c >= 0 && c == start_c + 1) begin
        @(negedge clk);
        check({tag, "_busy_after_start"}, int'(busy), 1);
      end
      if (n_results != base) begin
        lat = c - start_c;
        got = 1'b1;
        break;
      end
    end
    if (reset_at < 0) check({tag, "_result_seen"}, int'(got), 1);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int lat_full;
    int lat_half;
    int lat_tmp;
    int fired;
    int to_pulses;
    bit saw_rv;

    reset = 1'b1; sample_in = 8'd0; sample_valid = 1'b0; start = 1'b0;
    s8_sample = 8'd128; s8_valid = 1'b0; s8_start = 1'b0;

    // Reset held while start and sample_valid are also high: reset must win.
    repeat (3) step(8'd200, 1'b1, 1'b1, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_result_valid", int'(result_valid), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_period", int'(period_out), 0);
    check("rst_max", int'(max_out), 0);
    check("rst_min", int'(min_out), 0);

    // Sine, round(127.5 + 127.5*sin(2*pi*i/32)); crossings at 152 (rise) and 103 (fall).
    wave = '{8'd128, 8'd152, 8'd176, 8'd198, 8'd218, 8'd234, 8'd245, 8'd253,
             8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd198, 8'd176, 8'd152,
             8'd128, 8'd103, 8'd79,  8'd57,  8'd37,  8'd21,  8'd10,  8'd2,
             8'd0,   8'd2,   8'd10,  8'd21,  8'd37,  8'd57,  8'd79,  8'd103};
    drive_wave("sine", 1'b0, -1, lat_full);
    // Start on table index 0: ARM low at 17, first rise at 33, second rise at 65;
    // result visible two stimulus steps after that sample is driven.
    check("sine_latency", lat_full, 67);
    repeat (5) step(8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_period", int'(period_out), 32);
    check("hold_max", int'(max_out), 255);
    check("hold_min", int'(min_out), 0);
    check("idle_busy", int'(busy), 0);

    // Square: 16 x 255 then 16 x 0.
    for (int i = 0; i < 32; i++) wave[i] = (i < 16) ? 8'd255 : 8'd0;
    drive_wave("square", 1'b0, -1, lat_tmp);

    // ECG-like: baseline 72, spike 255 at index 10, undershoot 0 at index 11.
    for (int i = 0; i < 32; i++) wave[i] = 8'd72;
    wave[10] = 8'd255;
    wave[11] = 8'd0;
    drive_wave("ecg", 1'b0, -1, lat_tmp);

    // Sine accepted only every other cycle: same period, roughly twice the latency.
    wave = '{8'd128, 8'd152, 8'd176, 8'd198, 8'd218, 8'd234, 8'd245, 8'd253,
             8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd198, 8'd176, 8'd152,
             8'd128, 8'd103, 8'd79,  8'd57,  8'd37,  8'd21,  8'd10,  8'd2,
             8'd0,   8'd2,   8'd10,  8'd21,  8'd37,  8'd57,  8'd79,  8'd103};
    drive_wave("sine_half", 1'b1, -1, lat_half);
    check("half_rate_latency_2x", int'(lat_half >= 2 * lat_full - 4 &&
                                       lat_half <= 2 * lat_full + 4), 1);

    // Reset 55 samples after start lands in MEAS_HI; no pulse, everything cleared.
    drive_wave("sine_rst", 1'b0, 55, lat_tmp);
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_result_valid", int'(result_valid), 0);
    check("midrst_period", int'(period_out), 0);
    check("midrst_max", int'(max_out), 0);
    check("midrst_min", int'(min_out), 0);
    drive_wave("sine_after_rst", 1'b0, -1, lat_tmp);

    // Timeout with PERIOD_W=8 on a constant in-band input: 254 samples are counted,
    // the 255th would reach 255 and aborts the measurement.
    @(posedge clk); #1; s8_start = 1'b1;
    @(posedge clk); #1; s8_start = 1'b0; s8_valid = 1'b1;
    fired = -1; to_pulses = 0; saw_rv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 100) check("t8_busy_counting", int'(t8_busy), 1);
      if (t8_rv) saw_rv = 1'b1;
      if (t8_timeout) begin
        to_pulses++;
        if (fired < 0) begin
          fired = i;
          check("t8_busy_at_timeout", int'(t8_busy), 0);
        end
      end
    end
    check("t8_timeout_after_samples", fired, 255);
    check("t8_timeout_pulse_width", to_pulses, 1);
    check("t8_no_result_valid", int'(saw_rv), 0);
    check("t8_period_held", int'(t8_period), 0);
    check("t8_max_held", int'(t8_max), 0);
    check("t8_busy_end", int'(t8_busy), 0);
    s8_valid = 1'b0;

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
